// File: rtl/timer_seven_seg.sv
// MM:SS countdown timer with debounced minute adjust / run-pause buttons
// and a registered 4-digit multiplexed 7-segment driver.
module timer_seven_seg #(
  parameter int CLK_HZ          = 100000000,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REFRESH_BITS    = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btnU,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       mode,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam int PS_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_HZ - 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int B_U = 0;
  localparam int B_L = 1;
  localparam int B_R = 2;

  // ---------------------------------------------------------------------------
  // Button conditioning: synchronizer, debouncer, rising-edge pulse
  // ---------------------------------------------------------------------------
  logic [2:0]      btn_raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      db_level, db_prev;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      press;

  assign btn_raw = {btnR, btnL, btnU};

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      db_level <= '0;
      db_prev  <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      db_prev <= db_level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_level[i] <= sync2[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press = db_level & ~db_prev;

  // ---------------------------------------------------------------------------
  // Time keeping
  // ---------------------------------------------------------------------------
  logic [6:0]      min_q, min_t, min_n;
  logic [5:0]      sec_q, sec_t, sec_n;
  logic            running_q, run_t, run_n;
  logic [PS_W-1:0] presc_q, presc_n;
  logic            tick;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    tick    = running_q && (presc_q == PS_LAST);
    min_t   = min_q;
    sec_t   = sec_q;
    run_t   = running_q;
    presc_n = presc_q;

    if (tick) begin
      presc_n = '0;
      if (sec_q != 6'd0) begin
        sec_t = sec_q - 6'd1;
      end else if (min_q != 7'd0) begin
        min_t = min_q - 7'd1;
        sec_t = 6'd59;
      end
    end else if (running_q) begin
      presc_n = presc_q + PS_W'(1);
    end

    // Button actions see the post-tick value.
    min_n = min_t;
    sec_n = sec_t;
    run_n = run_t;
    if (!mode) begin
      if (press[B_R] && !press[B_L] && min_t != 7'd99) begin
        min_n = min_t + 7'd1;
      end else if (press[B_L] && !press[B_R] && min_t != 7'd0) begin
        min_n = min_t - 7'd1;
      end
      if (press[B_U]) begin
        if (run_t) begin
          run_n = 1'b0;
        end else if (min_n != 7'd0 || sec_n != 6'd0) begin
          run_n   = 1'b1;
          presc_n = '0;
        end
      end
    end

    if (min_n == 7'd0 && sec_n == 6'd0) run_n = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q     <= '0;
      sec_q     <= '0;
      running_q <= 1'b0;
      presc_q   <= '0;
    end else begin
      min_q     <= min_n;
      sec_q     <= sec_n;
      running_q <= run_n;
      presc_q   <= presc_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Display multiplexing
  // ---------------------------------------------------------------------------
  logic [REFRESH_BITS-1:0] refresh;
  logic [1:0]              sel;
  logic [3:0]              digit;
  logic [3:0]              an_n;
  logic [6:0]              seg_n;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign sel = refresh[REFRESH_BITS-1 -: 2];

  always_comb begin
    digit = '0;
    case (sel)
      2'd0: digit = 4'(sec_q % 6'd10);
      2'd1: digit = 4'(sec_q / 6'd10);
      2'd2: digit = 4'(min_q % 7'd10);
      2'd3: digit = 4'(min_q / 7'd10);
      default: digit = '0;
    endcase
    an_n  = ~(4'b0001 << sel);
    seg_n = seg_encode(digit);
  end

  // Anode and cathode registers share one update so they never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh <= '0;
      an      <= 4'b1110;
      seg     <= 7'b1000000;
    end else begin
      refresh <= refresh + REFRESH_BITS'(1);
      an      <= an_n;
      seg     <= seg_n;
    end
  end

endmodule

// File: tb/tb_timer_seven_seg.sv
// Directed bench for timer_seven_seg with small parameters; time is read back
// through the multiplexed display and, for cycle-exact checks, internal state.
module tb_timer_seven_seg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btnU = 1'b0, btnL = 1'b0, btnR = 1'b0, mode = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;

  int n_checks = 0;
  int n_fail   = 0;

  timer_seven_seg #(
    .CLK_HZ(10), .DEBOUNCE_CYCLES(4), .REFRESH_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .btnU(btnU), .btnL(btnL), .btnR(btnR),
    .mode(mode), .an(an), .seg(seg)
  );

  always #5 clk = ~clk;

  // Advance n rising edges; land on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    btnU = 0; btnL = 0; btnR = 0; mode = 0;
    reset = 1;
    cyc(2);
    reset = 0;
  endtask

  // which: 0=U, 1=L, 2=R, 3=L+R together
  task automatic press(input int which, input int hold);
    case (which)
      0: btnU = 1;
      1: btnL = 1;
      2: btnR = 1;
      default: begin btnL = 1; btnR = 1; end
    endcase
    cyc(hold);
    btnU = 0; btnL = 0; btnR = 0;
    cyc(hold);
  endtask

  function automatic int seg2dig(input logic [6:0] s);
    case (s)
      7'b1000000: return 0;
      7'b1111001: return 1;
      7'b0100100: return 2;
      7'b0110000: return 3;
      7'b0011001: return 4;
      7'b0010010: return 5;
      7'b0000010: return 6;
      7'b1111000: return 7;
      7'b0000000: return 8;
      7'b0010000: return 9;
      default:    return -100000;
    endcase
  endfunction

  // Scan the display for 20 cycles; val = MMSS as decimal, negative if broken.
  logic [6:0] disp_seg [4];
  task automatic read_display(output int val);
    bit seen [4];
    bit bad = 0;
    int v;
    for (int i = 0; i < 4; i++) seen[i] = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      case (an)
        4'b1110: begin disp_seg[0] = seg; seen[0] = 1; end
        4'b1101: begin disp_seg[1] = seg; seen[1] = 1; end
        4'b1011: begin disp_seg[2] = seg; seen[2] = 1; end
        4'b0111: begin disp_seg[3] = seg; seen[3] = 1; end
        default: bad = 1;
      endcase
    end
    v = seg2dig(disp_seg[3]) * 1000 + seg2dig(disp_seg[2]) * 100 +
        seg2dig(disp_seg[1]) * 10 + seg2dig(disp_seg[0]);
    if (bad || !seen[0] || !seen[1] || !seen[2] || !seen[3] || v < 0) val = -1;
    else val = v;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc(2);
    n_checks++;
    if (an !== 4'b1110) begin
      n_fail++; $display("FAIL reset_an: got %b expected 1110", an);
    end
    n_checks++;
    if (seg !== 7'b1000000) begin
      n_fail++; $display("FAIL reset_seg: got %b expected 1000000", seg);
    end
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd0 || dut.running_q !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got %0d:%0d run=%b expected 0:0 run=0",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    reset = 0;
    for (int n = 1; n <= 16; n++) begin
      cyc(1);
      exp_an = 4'b1111 ^ (4'b0001 << ((n - 1) >> 2));
      n_checks++;
      if (an !== exp_an || seg !== 7'b1000000) begin
        n_fail++; $display("FAIL scan_%0d: got an=%b seg=%b expected an=%b seg=1000000",
                           n, an, seg, exp_an);
      end
    end
  endtask

  task automatic test_minute_adjust();
    int v;
    do_reset();
    for (int i = 0; i < 3; i++) press(2, 10);
    read_display(v);
    n_checks++;
    if (v !== 300) begin n_fail++; $display("FAIL inc3: got %0d expected 300", v); end
    n_checks++;
    if (disp_seg[2] !== 7'b0110000) begin
      n_fail++; $display("FAIL inc3_seg: got %b expected 0110000", disp_seg[2]);
    end
    press(3, 10);
    read_display(v);
    n_checks++;
    if (v !== 300) begin n_fail++; $display("FAIL l_and_r: got %0d expected 300", v); end
    press(1, 10);
    read_display(v);
    n_checks++;
    if (v !== 200) begin n_fail++; $display("FAIL dec1: got %0d expected 200", v); end
    for (int i = 0; i < 3; i++) press(1, 10);
    read_display(v);
    n_checks++;
    if (v !== 0) begin n_fail++; $display("FAIL dec_to_0: got %0d expected 0", v); end
    press(1, 10);
    read_display(v);
    n_checks++;
    if (v !== 0) begin n_fail++; $display("FAIL dec_at_0: got %0d expected 0", v); end
  endtask

  task automatic test_saturation();
    int v;
    do_reset();
    for (int i = 0; i < 101; i++) press(2, 10);
    read_display(v);
    n_checks++;
    if (v !== 9900) begin n_fail++; $display("FAIL sat99: got %0d expected 9900", v); end
    n_checks++;
    if (disp_seg[3] !== 7'b0010000) begin
      n_fail++; $display("FAIL sat_seg: got %b expected 0010000", disp_seg[3]);
    end
  endtask

  task automatic test_countdown();
    int v, k;
    do_reset();
    press(2, 10);
    btnU = 1;
    cyc(6);
    n_checks++;
    if (dut.running_q !== 1'b0) begin
      n_fail++; $display("FAIL start_early: got run=%b expected 0", dut.running_q);
    end
    cyc(1);
    btnU = 0;
    n_checks++;
    if (dut.running_q !== 1'b1 || dut.min_q !== 7'd1 || dut.sec_q !== 6'd0) begin
      n_fail++; $display("FAIL start: got %0d:%0d run=%b expected 1:0 run=1",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
    cyc(9);
    n_checks++;
    if (dut.min_q !== 7'd1 || dut.sec_q !== 6'd0) begin
      n_fail++; $display("FAIL pre_tick: got %0d:%0d expected 1:0", dut.min_q, dut.sec_q);
    end
    cyc(1);
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd59) begin
      n_fail++; $display("FAIL borrow: got %0d:%0d expected 0:59", dut.min_q, dut.sec_q);
    end
    cyc(10);
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd58) begin
      n_fail++; $display("FAIL tick2: got %0d:%0d expected 0:58", dut.min_q, dut.sec_q);
    end
    k = 0;
    while (dut.running_q === 1'b1 && k < 1000) begin
      cyc(1);
      k++;
    end
    n_checks++;
    if (k !== 580 || dut.min_q !== 7'd0 || dut.sec_q !== 6'd0) begin
      n_fail++; $display("FAIL run_out: got %0d cycles %0d:%0d expected 580 cycles 0:0",
                         k, dut.min_q, dut.sec_q);
    end
    cyc(50);
    read_display(v);
    n_checks++;
    if (v !== 0 || dut.running_q !== 1'b0) begin
      n_fail++; $display("FAIL hold_zero: got %0d run=%b expected 0 run=0", v, dut.running_q);
    end
  endtask

  task automatic test_mode_and_glitch();
    do_reset();
    press(2, 10);
    btnU = 1;
    cyc(10);
    btnU = 0;
    cyc(10);
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd59 || dut.running_q !== 1'b1) begin
      n_fail++; $display("FAIL mode_pre: got %0d:%0d run=%b expected 0:59 run=1",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
    mode = 1;
    press(2, 10);
    press(0, 10);
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd55 || dut.running_q !== 1'b1) begin
      n_fail++; $display("FAIL mode_gate: got %0d:%0d run=%b expected 0:55 run=1",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
    mode = 0;
    btnR = 1;
    cyc(2);
    btnR = 0;
    cyc(20);
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd53) begin
      n_fail++; $display("FAIL glitch: got %0d:%0d expected 0:53", dut.min_q, dut.sec_q);
    end
  endtask

  task automatic test_async_reset();
    int v;
    do_reset();
    press(2, 10);
    press(2, 10);
    btnU = 1;
    cyc(7);
    btnU = 0;
    cyc(305);
    n_checks++;
    if (dut.min_q !== 7'd1 || dut.sec_q !== 6'd30 || dut.running_q !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got %0d:%0d run=%b expected 1:30 run=1",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
    #2 reset = 1;
    #1;
    n_checks++;
    if (an !== 4'b1110 || seg !== 7'b1000000) begin
      n_fail++; $display("FAIL async_out: got an=%b seg=%b expected 1110 1000000", an, seg);
    end
    n_checks++;
    if (dut.min_q !== 7'd0 || dut.sec_q !== 6'd0 || dut.running_q !== 1'b0) begin
      n_fail++; $display("FAIL async_state: got %0d:%0d run=%b expected 0:0 run=0",
                         dut.min_q, dut.sec_q, dut.running_q);
    end
    #1 reset = 0;
    @(negedge clk);
    cyc(30);
    read_display(v);
    n_checks++;
    if (v !== 0 || dut.running_q !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got %0d run=%b expected 0 run=0", v, dut.running_q);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_minute_adjust();
    test_saturation();
    test_countdown();
    test_mode_and_glitch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_seven_seg.md
Name: timer_seven_seg

Overview:
- Minutes:seconds countdown timer (MM:SS, 00:00–99:59) with button-driven minute adjustment and run/pause control.
- Drives the 4-digit multiplexed 7-segment display.
- Sits beside the VGA text path in the top level and shares btnL/btnR with it; the mode input selects which block owns those buttons.
- Contains its own debouncers and rising-edge detectors for btnU, btnL and btnR.

Parameters:
- CLK_HZ, 100000000: clock frequency; 1 s tick period in cycles.
- DEBOUNCE_CYCLES, 1000000: cycles a synchronized button level must be stable before it is accepted (10 ms).
- REFRESH_BITS, 18: width of the display refresh counter; top 2 bits select the digit.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-high; clears time to 00:00, stops the timer, clears all counters.
- btnU, input, 1: raw start/stop button, active-high.
- btnL, input, 1: raw "minus 1 minute" button.
- btnR, input, 1: raw "plus 1 minute" button.
- mode, input, 1: 0 = buttons control the timer; 1 = buttons ignored (owned by the VGA editor).
- an, output, 4: digit anodes, active-low; an[3] = minutes tens … an[0] = seconds units.
- seg, output, 7: cathodes, active-low; seg[0]=a … seg[6]=g.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous and active-high.
- Reset state:
  - min=0, sec=0, running=0; prescaler, refresh and debounce counters = 0.
  - an=4'b1110; seg shows "0" (7'b1000000).
- Button conditioning (each of btnU/btnL/btnR):
  - 2-flop synchronizer.
  - Debounced level changes only after the synchronized input has held a new value for DEBOUNCE_CYCLES consecutive cycles.
  - A one-cycle press pulse fires on the debounced rising edge; release generates nothing.
  - Press-to-pulse latency is DEBOUNCE_CYCLES + 3 cycles.
- Press pulses act only when mode==0. With mode==1 pulses are discarded; counting and display continue unchanged.
- btnU pulse:
  - If running: toggle to paused.
  - If paused and time≠00:00: start running and clear the prescaler, so the first decrement lands exactly CLK_HZ cycles later.
  - If paused at 00:00: ignored.
- btnR pulse: min=min+1, saturating at 99; sec unchanged. Allowed while running or paused.
- btnL pulse: if min>0 then min=min−1; sec unchanged. If min==0, no change.
- Tick and decrement:
  - The prescaler counts 0..CLK_HZ−1 only while running; tick = prescaler==CLK_HZ−1.
  - On tick, if sec>0 then sec−1; else if min>0 then min−1, sec=59.
  - Reaching 00:00 clears running in the same cycle. Display holds 00:00.
- Simultaneous events in one cycle:
  - Button action and tick: the button adjustment applies to the post-tick value.
  - btnL and btnR together: no change.
- Storage: min and sec are binary (7 and 6 bits); BCD digits are derived combinationally by /10 and %10.
- Display multiplexing:
  - Refresh counter free-runs; digit select = refresh[REFRESH_BITS-1 -: 2].
  - Select 0 drives an[0] (sec units), 1 → an[1] (sec tens), 2 → an[2] (min units), 3 → an[3] (min tens).
  - Exactly one anode is low at any time. an and seg are registered and updated together.
  - All four digits are always shown, leading zeros included.
- seg encodings (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Reset mid-operation: immediate return to the reset state, regardless of running or mode.

Test Plan:
All scenarios use CLK_HZ=10, DEBOUNCE_CYCLES=4, REFRESH_BITS=4.
- Reset/display:
  - Assert reset → an=1110, seg=1000000.
  - Release and scan 16 cycles → an cycles 1110, 1101, 1011, 0111, each digit showing 0.
- Minute adjust:
  - mode=0; press btnR 3×, each held 10 cycles → min=3 (an=1011 shows seg 0110000).
  - Press btnL once → min=2.
  - Press btnL 3 more times → min=0; further btnL leaves 00:00.
- Saturation: 101 btnR presses → min=99, display 99:00.
- Countdown/borrow:
  - Set 01:00; press btnU → 10 cycles later 00:59, then 00:58.
  - Run to 00:00 → running=0, value holds 00:00 for 50 more cycles.
- Mode gating and debounce:
  - mode=1: btnR/btnU presses leave time unchanged; a running countdown continues.
  - A 2-cycle glitch on btnR with mode=0 → no change.
- Async reset mid-run: at 01:30 running, pulse reset between clock edges → outputs immediately show 00:00; no tick follows.
